// File: rtl/pi_cmd_rx.sv
// Raspberry Pi GPIO command front end: synchronise, debounce, and run the dispense handshake.
// Define PI_CMD_TIMEOUT_EN to add a RUN watchdog of TIMEOUT_CYC cycles.
module pi_cmd_rx #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1024,
  parameter int TIMEOUT_CYC  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] pi_mode_i,
  input  logic [1:0] pi_amount_i,
  input  logic       pi_flag_i,
  input  logic       done_i,
  output logic [2:0] mode_o,
  output logic [1:0] amount_o,
  output logic       cmd_valid_o,
  output logic       dispense_o,
  output logic       ack_o,
  output logic       err_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYC < 2 || TIMEOUT_CYC < 2) begin : g_param_err
    $error("pi_cmd_rx: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, RUN, ACK, REJECT} state_t;

  // Bus layout: [5:3] mode, [2:1] amount, [0] flag
  logic [SYNC_STAGES-1:0][5:0] sync;
  logic [5:0]    synced, synced_q, filt;
  logic [CW-1:0] cnt;
  logic          upd, flag_q, armed, rise, fall, expire;

  assign synced = sync[SYNC_STAGES-1];
  assign upd    = (cnt == CW'(DEBOUNCE_CYC-1)) && (synced == synced_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync     <= '0;
      synced_q <= '0;
      cnt      <= '0;
      filt     <= '0;
      flag_q   <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync[0] <= {pi_mode_i, pi_amount_i, pi_flag_i};
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      synced_q <= synced;
      if (synced != synced_q) cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYC-1)) cnt <= cnt + CW'(1);
      if (upd) filt <= synced;
      // A flag held high through reset must be seen low before a rise counts
      if (upd && !synced[0]) armed <= 1'b1;
      flag_q <= filt[0];
    end
  end

  assign rise = filt[0] & ~flag_q & armed;
  assign fall = ~filt[0] & flag_q;

  state_t state, state_nx;

`ifdef PI_CMD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC+1);
  logic [WW-1:0] wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                wd <= '0;
    else if (state != RUN)  wd <= '0;
    else                    wd <= wd + WW'(1);
  end

  assign expire = (wd == WW'(TIMEOUT_CYC-1));
`else
  assign expire = 1'b0;
`endif

  logic [2:0] mode_d;
  logic [1:0] amount_d;
  logic       cv_d, disp_d, ack_d, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mode_o      <= '0;
      amount_o    <= '0;
      cmd_valid_o <= 1'b0;
      dispense_o  <= 1'b0;
      ack_o       <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_nx;
      mode_o      <= mode_d;
      amount_o    <= amount_d;
      cmd_valid_o <= cv_d;
      dispense_o  <= disp_d;
      ack_o       <= ack_d;
      err_o       <= err_d;
    end
  end

  // done beats watchdog expiry, which beats an abort by flag fall
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (rise) state_nx = (filt[2:1] == 2'b11) ? REJECT : RUN;
      RUN:         if (done_i)      state_nx = ACK;
                   else if (expire) state_nx = REJECT;
                   else if (fall)   state_nx = IDLE;
      ACK, REJECT: if (!filt[0]) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_o;
    amount_d = amount_o;
    cv_d     = 1'b0;
    if (state == IDLE && filt[5:3] != mode_o) begin
      mode_d = filt[5:3];
      cv_d   = 1'b1;
    end
    if (state == IDLE && state_nx == RUN) amount_d = filt[2:1];
    disp_d = (state_nx == RUN);
    ack_d  = (state_nx == ACK);
    err_d  = (state_nx == REJECT);
  end
endmodule

// File: tb/tb_pi_cmd_rx.sv
// Bench for pi_cmd_rx: directed scenarios plus a random phase, all outputs compared every
// cycle against a timing-level behavioural model.
module tb_pi_cmd_rx;
  localparam int SS = 2, DC = 4, TC = 100;
`ifdef PI_CMD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] pi_mode = '0;
  logic [1:0] pi_amount = '0;
  logic pi_flag = 1'b0, done = 1'b0;
  logic [2:0] mode;
  logic [1:0] amount;
  logic cmd_valid, dispense, ack, err;
  int errors = 0, checks = 0;
  int n, lat, pulses, seen, bad, ackc;

  always #5 clk = ~clk;

  pi_cmd_rx #(.SYNC_STAGES(SS), .DEBOUNCE_CYC(DC), .TIMEOUT_CYC(TC)) dut (
    .clk(clk), .rst(rst), .pi_mode_i(pi_mode), .pi_amount_i(pi_amount), .pi_flag_i(pi_flag),
    .done_i(done), .mode_o(mode), .amount_o(amount), .cmd_valid_o(cmd_valid),
    .dispense_o(dispense), .ack_o(ack), .err_o(err));

  // Reference model. Filtered bus: after edge t it takes raw(t-SS) when the raw samples of
  // edges t-SS-DC .. t-SS all agree and at least DC edges have passed since reset.
  typedef enum {P_IDLE, P_RUN, P_ACK, P_REJ} ph_t;
  ph_t m_ph;
  logic [5:0] hist [0:SS+DC];
  logic [5:0] m_filt;
  logic [2:0] m_mode;
  logic [1:0] m_amt;
  logic m_fprev, m_armed, m_cv, m_disp, m_ack, m_err, m_rise, m_fall, m_ok;
  int m_t, m_wd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= SS+DC; k++) hist[k] = 6'd0;
      m_t = 0; m_wd = 0; m_filt = 0; m_fprev = 0; m_armed = 0; m_ph = P_IDLE;
      m_mode = 0; m_amt = 0; m_cv = 0; m_disp = 0; m_ack = 0; m_err = 0;
    end else begin
      m_rise = m_filt[0] && !m_fprev && m_armed;
      m_fall = !m_filt[0] && m_fprev;
      m_cv = 1'b0;
      case (m_ph)
        P_IDLE: begin
          if (m_filt[5:3] != m_mode) begin m_mode = m_filt[5:3]; m_cv = 1'b1; end
          if (m_rise) begin
            if (m_filt[2:1] == 2'd3) m_ph = P_REJ;
            else begin m_amt = m_filt[2:1]; m_ph = P_RUN; m_wd = 0; end
          end
        end
        P_RUN: begin
          if (done) m_ph = P_ACK;
          else if (TO_EN && m_wd == TC-1) m_ph = P_REJ;
          else if (m_fall) m_ph = P_IDLE;
          else m_wd++;
        end
        default: if (!m_filt[0]) m_ph = P_IDLE;
      endcase
      m_disp = (m_ph == P_RUN);
      m_ack  = (m_ph == P_ACK);
      m_err  = (m_ph == P_REJ);
      m_fprev = m_filt[0];
      m_t++;
      for (int k = SS+DC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {pi_mode, pi_amount, pi_flag};
      m_ok = (m_t >= DC);
      for (int k = SS; k <= SS+DC; k++) if (hist[k] != hist[SS]) m_ok = 1'b0;
      if (m_ok) begin
        m_filt = hist[SS];
        if (!hist[SS][0]) m_armed = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      chk("mode_o", mode, m_mode);
      chk("amount_o", amount, m_amt);
      chk("cmd_valid_o", cmd_valid, m_cv);
      chk("dispense_o", dispense, m_disp);
      chk("ack_o", ack, m_ack);
      chk("err_o", err, m_err);
    end
  endtask

  task automatic wait_disp(input string tag);
    int w = 0;
    while (dispense !== 1'b1 && w < 30) begin cyc(1); w++; end
    chk(tag, dispense, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_amount"}, amount, 0);
    chk({tag, "_cv"}, cmd_valid, 0);
    chk({tag, "_disp"}, dispense, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    cyc(10);

    // Mode change: filtered at the 7th sampling edge, registered to mode_o one edge later
    pi_mode = 3'd5; lat = 0; pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (cmd_valid === 1'b1) pulses++;
      if (mode === 3'd5 && lat == 0) lat = i;
    end
    chk("mode_latency", lat, 8);
    chk("mode_pulses", pulses, 1);

    // Glitch of DC-1 cycles is filtered out
    pi_mode = 3'd3; cyc(3); pi_mode = 3'd5; pulses = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (cmd_valid === 1'b1) pulses++; end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_mode", mode, 5);

    // Normal dispense with done
    pi_amount = 2'd1; cyc(8); pi_flag = 1'b1;
    wait_disp("run_start");
    chk("run_amount", amount, 1);
    pi_amount = 2'd2; cyc(10);
    chk("run_amount_frozen", amount, 1);
    chk("run_still", dispense, 1);
    done = 1'b1; cyc(1); done = 1'b0;
    chk("ack_set", ack, 1);
    chk("ack_disp_off", dispense, 0);
    pi_flag = 1'b0; cyc(3);
    chk("ack_hold", ack, 1);
    cyc(7);
    chk("ack_clear", ack, 0);

    // Reject on amount 3
    pi_amount = 2'd3; cyc(8); pi_flag = 1'b1; seen = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (dispense === 1'b1) seen++; end
    chk("rej_err", err, 1);
    chk("rej_no_disp", seen, 0);
    pi_flag = 1'b0; cyc(10);
    chk("rej_clear", err, 0);

    // Abort by flag fall
    pi_amount = 2'd2; cyc(8); pi_flag = 1'b1;
    wait_disp("abort_start");
    chk("abort_amount", amount, 2);
    pi_flag = 1'b0; bad = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (ack === 1'b1 || err === 1'b1) bad++; end
    chk("abort_disp", dispense, 0);
    chk("abort_no_handshake", bad, 0);

    // done coincident with the debounced flag fall
    pi_amount = 2'd1; cyc(8); pi_flag = 1'b1;
    wait_disp("coinc_start");
    cyc(3); pi_flag = 1'b0; cyc(7);
    done = 1'b1; cyc(1); done = 1'b0;
    ackc = (ack === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin cyc(1); if (ack === 1'b1) ackc++; end
    chk("coinc_ack_cycles", ackc, 1);

    // Watchdog (or its absence)
    cyc(8); pi_flag = 1'b1;
    wait_disp("to_start");
`ifdef PI_CMD_TIMEOUT_EN
    n = 1;
    for (int i = 0; i < TC+20 && err !== 1'b1; i++) begin cyc(1); if (dispense === 1'b1) n++; end
    chk("to_err", err, 1);
    chk("to_run_cycles", n, TC);
`else
    cyc(500);
    chk("no_to_disp", dispense, 1);
`endif
    pi_flag = 1'b0; cyc(12);
    chk("to_idle_disp", dispense, 0);
    chk("to_idle_err", err, 0);

    // Reset mid-RUN with the flag held high
    pi_flag = 1'b1;
    wait_disp("rst_start");
    rst = 1'b1; #1;
    chk_zero("rst_mid_run");
    repeat (2) @(negedge clk);
    rst = 1'b0; seen = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (dispense === 1'b1) seen++; end
    chk("rst_no_disp", seen, 0);
    pi_flag = 1'b0; cyc(10); pi_flag = 1'b1;
    wait_disp("rst_rearm");
    pi_flag = 1'b0; cyc(12);

    // Random phase
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) pi_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) pi_amount = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) pi_flag = ~pi_flag;
      done = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    done = 1'b0; pi_flag = 1'b0; cyc(15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
